// File: rtl/door_lock_fsm_ctrl.sv
// Door lock controller: password verification with a three-strike freeze and
// a two-step (enter, re-enter) password change, driven by rising edges of confirm/switch.
module door_lock_fsm_ctrl (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [11:0] i_password,
  input  logic        i_confirm,
  input  logic        i_switch,
  output logic        o_correct,
  output logic        o_incorrect,
  output logic [1:0]  o_trials,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    ST_INIT        = 3'd0,
    ST_VERIFY      = 3'd1,
    ST_SET         = 3'd2,
    ST_SET_CONFIRM = 3'd3,
    ST_FREEZE      = 3'd4
  } state_e;

  state_e      state_q;
  logic [11:0] key_q;
  logic [11:0] cand_q;
  logic [1:0]  trials_q;
  logic        correct_q;
  logic        incorrect_q;
  logic        confirm_hist_q;
  logic        switch_hist_q;

  logic        confirm_rise_s;
  logic        switch_rise_s;

  // History starts at 0, so an input already high when reset releases counts as a rise.
  assign confirm_rise_s = i_confirm & ~confirm_hist_q;
  assign switch_rise_s  = i_switch  & ~switch_hist_q;

  // Control state, stored passwords, strike counter and one-cycle result pulses
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q        <= ST_INIT;
      key_q          <= 12'h000;
      cand_q         <= 12'h000;
      trials_q       <= 2'd0;
      correct_q      <= 1'b0;
      incorrect_q    <= 1'b0;
      confirm_hist_q <= 1'b0;
      switch_hist_q  <= 1'b0;
    end else begin
      confirm_hist_q <= i_confirm;
      switch_hist_q  <= i_switch;
      correct_q      <= 1'b0;
      incorrect_q    <= 1'b0;
      case (state_q)
        ST_INIT: begin
          if (confirm_rise_s) begin
            key_q   <= i_password;
            state_q <= ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (confirm_rise_s) begin
            if (i_password == key_q) begin
              correct_q <= 1'b1;
              trials_q  <= 2'd0;
            end else begin
              incorrect_q <= 1'b1;
              trials_q    <= trials_q + 2'd1;
              // Third consecutive miss locks the door out until reset.
              if (trials_q == 2'd2) begin
                state_q <= ST_FREEZE;
              end
            end
          end else if (switch_rise_s) begin
            state_q <= ST_SET;
          end
        end
        ST_SET: begin
          if (confirm_rise_s) begin
            cand_q  <= i_password;
            state_q <= ST_SET_CONFIRM;
          end
        end
        ST_SET_CONFIRM: begin
          if (confirm_rise_s) begin
            state_q <= ST_VERIFY;
            if (i_password == cand_q) begin
              key_q     <= cand_q;
              correct_q <= 1'b1;
              trials_q  <= 2'd0;
            end else begin
              incorrect_q <= 1'b1;
            end
          end
        end
        ST_FREEZE: begin
          trials_q <= 2'd3;
        end
        default: begin
          state_q  <= ST_INIT;
          trials_q <= 2'd0;
        end
      endcase
    end
  end

  assign o_correct   = correct_q;
  assign o_incorrect = incorrect_q;
  assign o_trials    = trials_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_door_lock_fsm_ctrl.sv
// Bench for door_lock_fsm_ctrl: directed vector table for the scripted scenarios,
// then random traffic compared against an abstract model of the lock rules.
module tb_door_lock_fsm_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic [11:0] i_password = 12'h000;
  logic        i_confirm = 1'b0;
  logic        i_switch = 1'b0;
  logic        o_correct;
  logic        o_incorrect;
  logic [1:0]  o_trials;
  logic [2:0]  o_state;

  int total = 0;
  int bad = 0;

  door_lock_fsm_ctrl dut (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_password (i_password),
    .i_confirm  (i_confirm),
    .i_switch   (i_switch),
    .o_correct  (o_correct),
    .o_incorrect(o_incorrect),
    .o_trials   (o_trials),
    .o_state    (o_state)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          rst;
    bit          conf;
    bit          sw;
    logic [11:0] pw;
    bit          ec;
    bit          ei;
    int          tr;
    int          st;
  } vec_t;

  vec_t vt[$];

  // Abstract model: mode 0=INIT 1=VERIFY 2=SET 3=SET_CONFIRM 4=FREEZE
  int          m_mode;
  logic [11:0] m_key, m_cand;
  int          m_tr;
  bit          m_cor, m_inc, m_prev_c, m_prev_s;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input bit ec, input bit ei, input int tr, input int st);
    chk({tag, ".correct"},   {15'd0, o_correct},   {15'd0, ec});
    chk({tag, ".incorrect"}, {15'd0, o_incorrect}, {15'd0, ei});
    chk({tag, ".trials"},    {14'd0, o_trials},    tr[15:0]);
    chk({tag, ".state"},     {13'd0, o_state},     st[15:0]);
  endtask

  task automatic model_reset();
    m_mode = 0; m_key = 12'h000; m_cand = 12'h000; m_tr = 0;
    m_cor = 1'b0; m_inc = 1'b0; m_prev_c = 1'b0; m_prev_s = 1'b0;
  endtask

  task automatic model_step(input bit c, input bit s, input logic [11:0] pw);
    bit rc, rs;
    rc = c && !m_prev_c;
    rs = s && !m_prev_s;
    m_prev_c = c;
    m_prev_s = s;
    m_cor = 1'b0;
    m_inc = 1'b0;
    if (m_mode == 0) begin
      if (rc) begin m_key = pw; m_mode = 1; end
    end else if (m_mode == 1) begin
      if (rc && pw == m_key) begin m_cor = 1'b1; m_tr = 0; end
      else if (rc) begin
        m_inc = 1'b1; m_tr = m_tr + 1;
        if (m_tr == 3) m_mode = 4;
      end else if (rs) m_mode = 2;
    end else if (m_mode == 2) begin
      if (rc) begin m_cand = pw; m_mode = 3; end
    end else if (m_mode == 3) begin
      if (rc) begin
        if (pw == m_cand) begin m_key = m_cand; m_cor = 1'b1; m_tr = 0; end
        else m_inc = 1'b1;
        m_mode = 1;
      end
    end
  endtask

  // Called #1 after a rising edge; leaves reset released #1 after a later edge.
  task automatic do_reset(input bit c, input bit s, input string tag);
    i_reset = 1'b0; i_confirm = c; i_switch = s;
    #1;
    check_all(tag, 1'b0, 1'b0, 0, 0);
    @(posedge i_clk); #1;
    check_all({tag, ".held"}, 1'b0, 1'b0, 0, 0);
    i_reset = 1'b1;
    model_reset();
  endtask

  task automatic step(input bit c, input bit s, input logic [11:0] pw);
    i_confirm = c; i_switch = s; i_password = pw;
    @(posedge i_clk); #1;
  endtask

  task automatic add_v(input bit rst, input bit c, input bit s, input logic [11:0] pw,
                       input bit ec, input bit ei, input int tr, input int st);
    vec_t v;
    v.rst = rst; v.conf = c; v.sw = s; v.pw = pw;
    v.ec = ec; v.ei = ei; v.tr = tr; v.st = st;
    vt.push_back(v);
  endtask

  initial begin
    // Unlock, three strikes, frozen
    add_v(1, 0, 0, 12'h000, 0, 0, 0, 0);
    add_v(0, 1, 0, 12'hBAD, 0, 0, 0, 1);
    add_v(0, 0, 0, 12'hBAD, 0, 0, 0, 1);
    add_v(0, 1, 0, 12'hBAD, 1, 0, 0, 1);
    add_v(0, 0, 0, 12'hBAD, 0, 0, 0, 1);
    add_v(0, 1, 0, 12'h666, 0, 1, 1, 1);
    add_v(0, 0, 0, 12'h666, 0, 0, 1, 1);
    add_v(0, 1, 0, 12'h666, 0, 1, 2, 1);
    add_v(0, 0, 0, 12'h666, 0, 0, 2, 1);
    add_v(0, 1, 0, 12'h666, 0, 1, 3, 4);
    add_v(0, 0, 0, 12'h666, 0, 0, 3, 4);
    add_v(0, 1, 1, 12'hBAD, 0, 0, 3, 4);
    add_v(0, 0, 0, 12'hBAD, 0, 0, 3, 4);
    add_v(0, 0, 1, 12'hBAD, 0, 0, 3, 4);
    // Password change, failed change, held confirm, confirm/switch collision
    add_v(1, 0, 0, 12'h000, 0, 0, 0, 0);
    add_v(0, 1, 0, 12'hBAD, 0, 0, 0, 1);
    add_v(0, 0, 0, 12'hBAD, 0, 0, 0, 1);
    add_v(0, 0, 1, 12'hBAD, 0, 0, 0, 2);
    add_v(0, 0, 1, 12'hBAD, 0, 0, 0, 2);
    add_v(0, 0, 0, 12'hBAD, 0, 0, 0, 2);
    add_v(0, 1, 1, 12'hCEB, 0, 0, 0, 3);
    add_v(0, 0, 0, 12'hCEB, 0, 0, 0, 3);
    add_v(0, 1, 0, 12'hCEB, 1, 0, 0, 1);
    add_v(0, 0, 0, 12'hCEB, 0, 0, 0, 1);
    add_v(0, 1, 0, 12'hCEB, 1, 0, 0, 1);
    add_v(0, 0, 0, 12'hCEB, 0, 0, 0, 1);
    add_v(0, 1, 0, 12'hBAD, 0, 1, 1, 1);
    add_v(0, 0, 0, 12'hBAD, 0, 0, 1, 1);
    add_v(0, 0, 1, 12'hBAD, 0, 0, 1, 2);
    add_v(0, 0, 0, 12'hBAD, 0, 0, 1, 2);
    add_v(0, 1, 0, 12'h123, 0, 0, 1, 3);
    add_v(0, 0, 0, 12'h123, 0, 0, 1, 3);
    add_v(0, 1, 0, 12'h124, 0, 1, 1, 1);
    add_v(0, 0, 0, 12'h124, 0, 0, 1, 1);
    add_v(0, 1, 0, 12'hCEB, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) add_v(0, 1, 0, 12'hCEB, 0, 0, 0, 1);
    add_v(0, 0, 0, 12'hCEB, 0, 0, 0, 1);
    add_v(0, 1, 1, 12'hCEB, 1, 0, 0, 1);
    add_v(0, 0, 0, 12'hCEB, 0, 0, 0, 1);
    // Reset in the middle of a change discards the old key
    add_v(0, 0, 1, 12'hCEB, 0, 0, 0, 2);
    add_v(0, 0, 0, 12'hCEB, 0, 0, 0, 2);
    add_v(0, 1, 0, 12'h777, 0, 0, 0, 3);
    add_v(0, 0, 0, 12'h777, 0, 0, 0, 3);
    add_v(1, 0, 0, 12'h000, 0, 0, 0, 0);
    add_v(0, 1, 0, 12'h111, 0, 0, 0, 1);
    add_v(0, 0, 0, 12'h111, 0, 0, 0, 1);
    add_v(0, 1, 0, 12'hCEB, 0, 1, 1, 1);

    @(posedge i_clk); #1;
    for (int i = 0; i < vt.size(); i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      if (vt[i].rst) begin
        do_reset(vt[i].conf, vt[i].sw, tag);
      end else begin
        step(vt[i].conf, vt[i].sw, vt[i].pw);
        check_all(tag, vt[i].ec, vt[i].ei, vt[i].tr, vt[i].st);
      end
    end

    // Confirm already high while reset releases is a rising edge; key 000 is usable
    do_reset(1'b1, 1'b0, "rel");
    step(1'b1, 1'b0, 12'h000);
    check_all("rel.first", 1'b0, 1'b0, 0, 1);
    step(1'b0, 1'b0, 12'h000);
    check_all("rel.idle", 1'b0, 1'b0, 0, 1);
    step(1'b1, 1'b0, 12'h000);
    check_all("rel.key0", 1'b1, 1'b0, 0, 1);

    // Random traffic against the model
    do_reset(1'b0, 1'b0, "rnd.rst");
    for (int n = 0; n < 3000; n++) begin
      bit c, s;
      logic [11:0] pw;
      int sel;
      if ($urandom_range(0, 149) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "rnd.rst");
      end else begin
        c = ($urandom_range(0, 99) < 45);
        s = ($urandom_range(0, 99) < 30);
        sel = $urandom_range(0, 3);
        if (sel == 0)      pw = m_key;
        else if (sel == 1) pw = m_cand;
        else if (sel == 2) pw = 12'h666;
        else               pw = 12'($urandom);
        step(c, s, pw);
        model_step(c, s, pw);
        check_all("rnd", m_cor, m_inc, m_tr, m_mode);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
